// File: rtl/mv_uinst_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mv_uinst_gen_pkg
//  Purpose  : Shared widths, FSM state encodings and accumulator-op codes
//             for the matrix-vector micro-instruction generator.
//  Revision : 1.0  initial release
// ============================================================================
package mv_uinst_gen_pkg;

    // Default slice geometry
    localparam int MVU_TAGW        = 4;
    localparam int MVU_RF_DEPTH    = 256;
    localparam int MVU_RF_ADDRW    = $clog2(MVU_RF_DEPTH);
    localparam int MVU_ACCUM_ADDRW = 4;
    localparam int MVU_LENW        = 8;
    localparam int MVU_ROWSW       = 8;
    localparam int MVU_UIW         = MVU_TAGW + MVU_RF_ADDRW + 1 + MVU_ACCUM_ADDRW + 2;

    // Accumulator operation encodings carried in the low two uinst bits
    localparam logic [1:0] ACC_OP_SET      = 2'b00;
    localparam logic [1:0] ACC_OP_ACC      = 2'b01;
    localparam logic [1:0] ACC_OP_SET_EMIT = 2'b10;
    localparam logic [1:0] ACC_OP_ACC_EMIT = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mv_uinst_gen.sv
`default_nettype none
// ============================================================================
//  Module   : mv_uinst_gen
//  Purpose  : Expands one macro matrix-vector instruction into the per-cycle
//             micro-instruction stream {tag, rf_addr, load, accum_addr, op}
//             consumed by a matrix-vector slice.
//  Revision : 1.0  initial release
// ============================================================================
module mv_uinst_gen
    import mv_uinst_gen_pkg::*;
#(
    parameter int TAGW        = MVU_TAGW,
    parameter int MV_RF_ADDRW = MVU_RF_ADDRW,
    parameter int ACCUM_ADDRW = MVU_ACCUM_ADDRW,
    parameter int LENW        = MVU_LENW,
    parameter int ROWSW       = MVU_ROWSW,
    parameter int MVSLICE_UIW = TAGW + MV_RF_ADDRW + 1 + ACCUM_ADDRW + 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TAGW-1:0]        i_minst_tag,
    input  logic [MV_RF_ADDRW-1:0] i_minst_rf_base,
    input  logic [LENW-1:0]        i_minst_len,
    input  logic [ROWSW-1:0]       i_minst_rows,
    input  logic [ACCUM_ADDRW-1:0] i_minst_accum_base,
    input  logic                   i_minst_valid,
    output logic                   o_minst_ready,
    output logic [MVSLICE_UIW-1:0] o_uinst_data,
    output logic                   o_uinst_valid,
    input  logic                   i_uinst_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [TAGW-1:0]        r_tag;
    logic [LENW-1:0]        r_len;
    logic [ROWSW-1:0]       r_rows;
    logic [MV_RF_ADDRW-1:0] r_ptr;      // running register-file pointer
    logic [ACCUM_ADDRW-1:0] r_aptr;     // accumulator address of current row
    logic [ROWSW-1:0]       r_row;
    logic [LENW-1:0]        r_col;
    logic                   r_uvalid;
    logic [MVSLICE_UIW-1:0] r_udata;

    logic w_accept;
    logic w_load;
    logic w_col_last;
    logic w_row_last;
    logic w_first;
    logic w_xfer;
    logic [1:0] w_op;

    assign w_accept   = (r_state == ST_IDLE) && i_minst_valid;
    // Output register is free when empty or being drained this cycle
    assign w_load     = (r_state == ST_ISSUE) && (!r_uvalid || i_uinst_ready);
    assign w_xfer     = r_uvalid && i_uinst_ready;
    assign w_col_last = (r_col == r_len - LENW'(1));
    assign w_row_last = (r_row == r_rows - ROWSW'(1));
    assign w_first    = (r_row == '0) && (r_col == '0);

    // Accumulator op for the chunk about to be loaded
    always_comb begin
        w_op = ACC_OP_ACC;
        if (r_col == '0) begin
            w_op = (r_len == LENW'(1)) ? ACC_OP_SET_EMIT : ACC_OP_SET;
        end else if (w_col_last) begin
            w_op = ACC_OP_ACC_EMIT;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_minst_valid) begin
                    w_state_nxt = ((i_minst_len == '0) || (i_minst_rows == '0)) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_load && w_col_last && w_row_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State-derived status outputs
    always_comb begin
        o_minst_ready = (r_state == ST_IDLE);
        o_busy        = (r_state != ST_IDLE);
        o_done        = (r_state == ST_FINISH);
    end

    // Macro field latch, row/chunk counters and registered uinst output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag    <= '0;
            r_len    <= '0;
            r_rows   <= '0;
            r_ptr    <= '0;
            r_aptr   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_uvalid <= 1'b0;
            r_udata  <= '0;
        end else if (w_accept) begin
            r_tag  <= i_minst_tag;
            r_len  <= i_minst_len;
            r_rows <= i_minst_rows;
            r_ptr  <= i_minst_rf_base;
            r_aptr <= i_minst_accum_base;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_load) begin
            r_udata  <= {r_tag, r_ptr, w_first, r_aptr, w_op};
            r_uvalid <= 1'b1;
            r_ptr    <= r_ptr + MV_RF_ADDRW'(1);
            if (w_col_last) begin
                r_col  <= '0;
                r_row  <= r_row + ROWSW'(1);
                r_aptr <= r_aptr + ACCUM_ADDRW'(1);
            end else begin
                r_col  <= r_col + LENW'(1);
            end
        end else if (w_xfer) begin
            r_uvalid <= 1'b0;
        end
    end

    assign o_uinst_valid = r_uvalid;
    assign o_uinst_data  = r_udata;

endmodule
`default_nettype wire

// File: tb/tb_mv_uinst_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mv_uinst_gen
//  Purpose  : Directed self-checking bench for mv_uinst_gen.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mv_uinst_gen;
    import mv_uinst_gen_pkg::*;

    localparam int UIW = MVU_UIW;

    logic                       clk;
    logic                       rst_n;
    logic [MVU_TAGW-1:0]        minst_tag;
    logic [MVU_RF_ADDRW-1:0]    minst_rf_base;
    logic [MVU_LENW-1:0]        minst_len;
    logic [MVU_ROWSW-1:0]       minst_rows;
    logic [MVU_ACCUM_ADDRW-1:0] minst_accum_base;
    logic                       minst_valid;
    logic                       minst_ready;
    logic [UIW-1:0]             uinst_data;
    logic                       uinst_valid;
    logic                       uinst_ready;
    logic                       busy;
    logic                       done;

    int n_checks = 0;
    int n_pass   = 0;

    mv_uinst_gen dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_minst_tag        (minst_tag),
        .i_minst_rf_base    (minst_rf_base),
        .i_minst_len        (minst_len),
        .i_minst_rows       (minst_rows),
        .i_minst_accum_base (minst_accum_base),
        .i_minst_valid      (minst_valid),
        .o_minst_ready      (minst_ready),
        .o_uinst_data       (uinst_data),
        .o_uinst_valid      (uinst_valid),
        .i_uinst_ready      (uinst_ready),
        .o_busy             (busy),
        .o_done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference uinst for flat index i of a macro, built from the closed form
    function automatic logic [UIW-1:0] exp_uinst(input int tag, input int base, input int len,
                                                input int abase, input int i);
        int r, c;
        logic [1:0] op;
        logic [MVU_TAGW-1:0] t;
        logic [MVU_RF_ADDRW-1:0] rf;
        logic [MVU_ACCUM_ADDRW-1:0] aa;
        logic ld;
        r = i / len;
        c = i % len;
        if (len == 1)        op = 2'b10;
        else if (c == 0)     op = 2'b00;
        else if (c == len-1) op = 2'b11;
        else                 op = 2'b01;
        t  = MVU_TAGW'(tag);
        rf = MVU_RF_ADDRW'((base + r*len + c) % MVU_RF_DEPTH);
        aa = MVU_ACCUM_ADDRW'((abase + r) % (1 << MVU_ACCUM_ADDRW));
        ld = (i == 0);
        return {t, rf, ld, aa, op};
    endfunction

    // Issue one macro, collect the uinst stream until done, compare with the model.
    // bp selects the 1,0,0,1,0,1 ready pattern; exp_first/exp_done < 0 skips timing checks.
    task automatic run_macro(input int tag, input int base, input int len, input int rows,
                             input int abase, input bit bp, input int exp_first, input int exp_done);
        logic [UIW-1:0] got_q[$];
        logic [UIW-1:0] prev_data;
        bit prev_stall;
        bit seen_done;
        int first_k, done_k, n_exp;
        bit pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        prev_stall = 1'b0;
        prev_data  = '0;
        seen_done  = 1'b0;
        first_k    = -1;
        done_k     = -1;
        n_exp      = len * rows;

        @(negedge clk);
        check("minst_ready_idle", {31'd0, minst_ready}, 32'd1);
        minst_tag        = MVU_TAGW'(tag);
        minst_rf_base    = MVU_RF_ADDRW'(base);
        minst_len        = MVU_LENW'(len);
        minst_rows       = MVU_ROWSW'(rows);
        minst_accum_base = MVU_ACCUM_ADDRW'(abase);
        minst_valid      = 1'b1;
        uinst_ready      = 1'b1;
        @(negedge clk);
        minst_valid = 1'b0;
        for (int k = 0; k < 200 && !seen_done; k++) begin
            if (k > 0) @(negedge clk);
            uinst_ready = bp ? pat[k % 6] : 1'b1;
            if (prev_stall) begin
                check("stall_valid", {31'd0, uinst_valid}, 32'd1);
                check("stall_data", 32'(uinst_data), 32'(prev_data));
            end
            if (uinst_valid && first_k < 0) first_k = k;
            if (uinst_valid && uinst_ready) got_q.push_back(uinst_data);
            prev_stall = uinst_valid && !uinst_ready;
            prev_data  = uinst_data;
            if (done) begin
                seen_done = 1'b1;
                done_k    = k;
            end
        end
        check("done_seen", {31'd0, seen_done}, 32'd1);
        if (exp_first >= 0) check("first_latency", 32'(first_k), 32'(exp_first));
        if (exp_done >= 0)  check("done_cycle", 32'(done_k), 32'(exp_done));
        check("uinst_count", 32'(got_q.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < got_q.size(); i++)
            check($sformatf("uinst[%0d]", i), 32'(got_q[i]), 32'(exp_uinst(tag, base, len, abase, i)));
        @(negedge clk);
        check("done_one_pulse", {31'd0, done}, 32'd0);
        check("ready_after", {31'd0, minst_ready}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        minst_tag        = '0;
        minst_rf_base    = '0;
        minst_len        = '0;
        minst_rows       = '0;
        minst_accum_base = '0;
        minst_valid      = 1'b0;
        uinst_ready      = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, uinst_valid}, 32'd0);
        check("rst_data", 32'(uinst_data), 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", {31'd0, minst_ready}, 32'd1);

        // Basic expansion: one uinst per cycle, first one cycle after accept
        run_macro(3, 10, 3, 2, 5, 1'b0, 1, 7);
        // len=1 with accumulator address wrap
        run_macro(1, 40, 1, 4, (1 << MVU_ACCUM_ADDRW) - 2, 1'b0, 1, 5);
        // Backpressure: identical stream, data held while stalled
        run_macro(3, 10, 3, 2, 5, 1'b1, -1, -1);
        // Zero count: no uinsts, done still pulses
        run_macro(7, 20, 0, 5, 0, 1'b0, -1, 0);
        // RF pointer wrap, also proves the macro after a zero-count one is accepted
        run_macro(2, MVU_RF_DEPTH - 1, 2, 1, 3, 1'b0, 1, 3);

        // Reset in the middle of a macro
        @(negedge clk);
        minst_tag = 4'd5; minst_rf_base = 8'd100; minst_len = 8'd3;
        minst_rows = 8'd2; minst_accum_base = 4'd1; minst_valid = 1'b1;
        uinst_ready = 1'b1;
        @(negedge clk);
        minst_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_valid_before", {31'd0, uinst_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_async_valid", {31'd0, uinst_valid}, 32'd0);
        check("mid_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", {31'd0, minst_ready}, 32'd1);
        check("mid_rel_valid", {31'd0, uinst_valid}, 32'd0);
        run_macro(5, 100, 3, 2, 1, 1'b0, 1, 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mv_uinst_gen.md
Name: mv_uinst_gen

Overview:
- Front-end sequencer for one matrix-vector slice: accepts one macro matrix-vector instruction and expands it into the per-cycle micro-instruction stream the slice's instruction FIFO consumes.
- Micro-instruction fields: tag, rf_addr, load, accum_addr, accum_op.
- Sits between the MVU instruction decoder and the slice instruction port.
- Backpressure comes from the slice's almost-full-based ready.

Parameters:
- TAGW, `TAGW, tag field width.
- MV_RF_ADDRW, $clog2(`MV_RF_DEPTH), register-file address width.
- ACCUM_ADDRW, `ACCUM_ADDRW, accumulator address width.
- LENW, 8, width of chunks-per-row count.
- ROWSW, 8, width of row count.
- MVSLICE_UIW, TAGW+MV_RF_ADDRW+1+ACCUM_ADDRW+2, micro-instruction width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_minst_tag  in  TAGW  tag stamped on every generated uinst
- i_minst_rf_base  in  MV_RF_ADDRW  first register-file address
- i_minst_len  in  LENW  chunks per output row (dot-product segments)
- i_minst_rows  in  ROWSW  output rows
- i_minst_accum_base  in  ACCUM_ADDRW  accumulator address of row 0
- i_minst_valid  in  1  macro valid
- o_minst_ready  out  1  macro ready (high only in IDLE)
- o_uinst_data  out  MVSLICE_UIW  packed {tag, rf_addr, load, accum_addr, accum_op}
- o_uinst_valid  out  1  uinst valid
- i_uinst_ready  in  1  slice instruction-port ready
- o_busy  out  1  macro in progress
- o_done  out  1  one-cycle pulse after last uinst of a macro is accepted

Behaviour:
- Reset (rst_n low, async): state IDLE; o_uinst_valid=0; o_uinst_data=0; o_done=0; o_busy=0; o_minst_ready=1 once reset deasserts; all counters 0.
- Reset mid-macro: abandons the macro immediately; no partial uinst is emitted after release.
- Handshakes:
  - Macro accepted on i_minst_valid && o_minst_ready.
  - Uinst transfers on o_uinst_valid && i_uinst_ready.
  - o_uinst_data and o_uinst_valid are registered and held stable while valid && !ready.
- FSM:
  - IDLE: o_minst_ready=1. On accept, latch all fields, clear r=0 and c=0.
    - If len==0 or rows==0: go to FINISH with no uinst.
    - Otherwise go to ISSUE.
  - ISSUE: output register loads the next uinst when !o_uinst_valid || i_uinst_ready. Counters advance on each load: c++, and at c==len-1 then c=0, r++.
    - After loading the final uinst (r==rows-1, c==len-1), go to DRAIN.
  - DRAIN: wait for the final transfer, then go to FINISH.
  - FINISH: o_done=1 for one cycle, then IDLE.
- o_busy=1 in ISSUE, DRAIN and FINISH.
- Minimum cycles from macro accept to first o_uinst_valid: 1.
- Throughput: 1 uinst/cycle while ready is held high.
- Field generation for row r, chunk c:
  - rf_addr = rf_base + r*len + c, computed incrementally (running pointer +1), modulo 2^MV_RF_ADDRW.
  - accum_addr = accum_base + r, modulo 2^ACCUM_ADDRW (wraps silently).
  - load = 1 only for r==0 && c==0.
  - accum_op:
    - 2'b00 SET: c==0, len>1.
    - 2'b01 ACC: 0<c<len-1.
    - 2'b10 SET_EMIT: c==0, len==1.
    - 2'b11 ACC_EMIT: c==len-1, len>1.
- Ready deasserting while valid: hold the data; the counters do not advance.
- The slice's ready is almost-full based, so the generator never needs to drop or retract a uinst.
- Back-to-back macros: the next macro may be accepted in the cycle after FINISH. No overlap of macros.

Decomposition:
- npu.vh gains:
  - accum_op encodings (SET, ACC, SET_EMIT, ACC_EMIT);
  - a `mvslice_uinst_pack(tag, rf, load, aaddr, op) macro mirroring the existing `mvslice_uinst_* field extractors, so packing and unpacking share one layout.
- Single module; no sub-module needed.
- Optional sub-module mv_uinst_counter (r/c nest plus pointer increment) if reused by the eVRF sequencer.

Test Plan:
- Basic expansion:
  - Stimulus: tag=3, rf_base=10, len=3, rows=2, accum_base=5, ready always 1.
  - Required: 6 uinsts, one per cycle.
    - rf 10..15.
    - accum 5,5,5,6,6,6.
    - op SET,ACC,ACC_EMIT,SET,ACC,ACC_EMIT.
    - load only on first.
    - All tag=3.
  - Then o_done pulses once.
- len=1:
  - Stimulus: len=1, rows=4, accum_base=2^ACCUM_ADDRW-2.
  - Required: 4 uinsts, all op SET_EMIT, accum_addr wraps to 0 and 1.
- Backpressure:
  - Stimulus: same as basic expansion, ready toggles 1,0,0,1,0,1...
  - Required: data stable while stalled; identical 6-uinst sequence; no duplicates or skips.
- Zero count:
  - Stimulus: len=0, rows=5.
  - Required: no o_uinst_valid; o_done pulses; next macro accepted.
- Reset mid-macro:
  - Stimulus: assert rst_n=0 during the 3rd uinst.
  - Required: o_uinst_valid drops asynchronously; after release o_minst_ready=1 and a new macro restarts from rf_base.
- RF wrap:
  - Stimulus: rf_base=2^MV_RF_ADDRW-1, len=2, rows=1.
  - Required: rf_addr = max, then 0.
